apb_reg_bank: RTL and testbench

Register bank that consumes the register-side request bus of the APB slave interface (addr, wdata, w_strb, write_en, read_en) and produces its response signals (rdata, rd_ready, wr_ready, err_resp). It holds four 32-bit registers: CTRL, SCRATCH, STATUS and INT_STAT. Programmable wait states are inserted via a small FSM and counter. Unmapped or illegal accesses are flagged with err_resp, and a level interrupt is driven to the system.

---
 rtl/apb_reg_pkg.sv | 25 ++
 rtl/apb_reg_bank_if.sv | 26 ++
 rtl/apb_wait_ctr.sv | 27 ++
 rtl/apb_reg_bank.sv | 164 ++++++++++++++++
 tb/tb_apb_reg_bank.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_reg_pkg.sv
// Shared constants, FSM encoding and decode helper for the APB register bank.
// Pure declarations: no latency, no flow control.
// Imported by the bank top; the interface and counter stand alone.
package apb_reg_pkg;

    localparam int INT_W = 8;

    localparam logic [11:0] ADDR_CTRL     = 12'h000;
    localparam logic [11:0] ADDR_SCRATCH  = 12'h004;
    localparam logic [11:0] ADDR_STATUS   = 12'h008;
    localparam logic [11:0] ADDR_INT_STAT = 12'h00C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // STATUS is read-only, so a write to it is treated as a decode error.
    function automatic logic addr_err(input logic [11:0] a, input logic is_wr);
        return (a[11:4] != 8'h00) || (a[1:0] != 2'b00) || (is_wr && a == ADDR_STATUS);
    endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// Register-side request/response bundle between the APB slave front end and the bank.
// Wires only: no latency of its own.
// Completion is signalled by one-cycle rd_ready / wr_ready pulses.
interface apb_reg_bank_if;

    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  w_strb;
    logic        write_en;
    logic        read_en;
    logic [31:0] rdata;
    logic        rd_ready;
    logic        wr_ready;
    logic        err_resp;

    modport master (
        output addr, wdata, w_strb, write_en, read_en,
        input  rdata, rd_ready, wr_ready, err_resp
    );

    modport slave (
        input  addr, wdata, w_strb, write_en, read_en,
        output rdata, rd_ready, wr_ready, err_resp
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// 4-bit loadable down-counter with zero flag used to insert access wait states.
// Load and decrement take effect at the next edge; zero is combinational from the count.
// No flow control: the controlling FSM decides when to load or decrement.
module apb_wait_ctr (
    input  logic       pclk,
    input  logic       prst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_reg_bank.sv
// Four-register APB bank (CTRL, SCRATCH, STATUS, INT_STAT) with level interrupt output.
// Read: ready 2+RD_WAIT cycles after setup; write: ready 2+WR_WAIT cycles after access start.
// Requests are only accepted in IDLE; the master holds them until the ready pulse.
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int unsigned RD_WAIT     = 1,
    parameter int unsigned WR_WAIT     = 0,
    parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
    input  logic             pclk,
    input  logic             prst_n,
    apb_reg_bank_if.slave    bus,
    output logic [31:0]      ctrl_out,
    input  logic [31:0]      status_in,
    input  logic [INT_W-1:0] int_set,
    output logic             irq
);

    localparam logic [3:0] RD_W = 4'(RD_WAIT);
    localparam logic [3:0] WR_W = 4'(WR_WAIT);

    state_t state_q, state_d;
    logic ctr_load, ctr_dec, ctr_zero;
    logic [3:0] ctr_val;
    logic cap_rd, cap_wr, done_rd, done_wr;

    logic [31:0] rdata_q, ctrl_q, scratch_q, ctrl_d, scratch_d, rd_val, wr_dat_q;
    logic [11:0] wr_addr_q;
    logic [3:0]  wr_strb_q;
    logic [INT_W-1:0] int_stat_q, int_d, clr;
    logic err_lat, rd_rdy_q, wr_rdy_q, err_resp_q, commit;

    apb_wait_ctr u_wait_ctr (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_val  = 4'd0;
        ctr_dec  = 1'b0;
        cap_rd   = 1'b0;
        cap_wr   = 1'b0;
        done_rd  = 1'b0;
        done_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read_en) begin
                    cap_rd   = 1'b1;
                    ctr_load = 1'b1;
                    ctr_val  = RD_W;
                    state_d  = RWAIT;
                end else if (bus.write_en) begin
                    cap_wr   = 1'b1;
                    ctr_load = 1'b1;
                    ctr_val  = WR_W;
                    state_d  = WWAIT;
                end
            end
            RWAIT: begin
                if (ctr_zero) begin
                    done_rd = 1'b1;
                    state_d = DONE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            WWAIT: begin
                if (ctr_zero) begin
                    done_wr = 1'b1;
                    state_d = DONE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'h0;
        case (bus.addr[3:2])
            2'd0: rd_val = ctrl_q;
            2'd1: rd_val = scratch_q;
            2'd2: rd_val = status_in;
            2'd3: rd_val = {{(32-INT_W){1'b0}}, int_stat_q};
            default: rd_val = 32'h0;
        endcase
    end

    // wr_ready is high exactly during DONE of a write, so the commit lands on the edge ending DONE.
    assign commit = wr_rdy_q && !err_lat;

    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        clr       = '0;
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_q[i] && wr_addr_q == ADDR_CTRL)
                    ctrl_d[8*i +: 8] = wr_dat_q[8*i +: 8];
                if (wr_strb_q[i] && wr_addr_q == ADDR_SCRATCH)
                    scratch_d[8*i +: 8] = wr_dat_q[8*i +: 8];
            end
            if (wr_addr_q == ADDR_INT_STAT && wr_strb_q[0])
                clr = wr_dat_q[INT_W-1:0];
        end
        int_d = (int_stat_q & ~clr) | int_set;
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            rdata_q    <= 32'h0;
            ctrl_q     <= 32'h0;
            scratch_q  <= SCRATCH_RST;
            int_stat_q <= '0;
            irq        <= 1'b0;
            rd_rdy_q   <= 1'b0;
            wr_rdy_q   <= 1'b0;
            err_resp_q <= 1'b0;
            err_lat    <= 1'b0;
            wr_addr_q  <= 12'h0;
            wr_dat_q   <= 32'h0;
            wr_strb_q  <= 4'h0;
        end else begin
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            int_stat_q <= int_d;
            irq        <= |(int_d & ctrl_d[INT_W-1:0]);
            rd_rdy_q   <= done_rd;
            wr_rdy_q   <= done_wr;
            err_resp_q <= (done_rd || done_wr) && err_lat;
            if (cap_rd) begin
                rdata_q <= addr_err(bus.addr, 1'b0) ? 32'h0 : rd_val;
                err_lat <= addr_err(bus.addr, 1'b0);
            end
            if (cap_wr) begin
                wr_addr_q <= bus.addr;
                wr_dat_q  <= bus.wdata;
                wr_strb_q <= bus.w_strb;
                err_lat   <= addr_err(bus.addr, 1'b1);
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_ready = rd_rdy_q;
    assign bus.wr_ready = wr_rdy_q;
    assign bus.err_resp = err_resp_q;
    assign ctrl_out     = ctrl_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Randomized self-checking bench for apb_reg_bank against a behavioural register model.
module tb_apb_reg_bank;

    localparam int          RD_WAIT = 1;
    localparam int          WR_WAIT = 2;
    localparam logic [31:0] SCR_RST = 32'hA5A5_0000;

    logic        pclk = 1'b0;
    logic        prst_n;
    logic [31:0] ctrl_out;
    logic [31:0] status_in;
    logic [7:0]  int_set;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_ctrl, m_scratch;
    logic [7:0]  m_int;

    apb_reg_bank_if bus();

    apb_reg_bank #(
        .RD_WAIT     (RD_WAIT),
        .WR_WAIT     (WR_WAIT),
        .SCRATCH_RST (SCR_RST)
    ) dut (
        .pclk      (pclk),
        .prst_n    (prst_n),
        .bus       (bus),
        .ctrl_out  (ctrl_out),
        .status_in (status_in),
        .int_set   (int_set),
        .irq       (irq)
    );

    always #5 pclk = ~pclk;

    function automatic bit m_err(input logic [11:0] a, input bit is_wr);
        return (a > 12'd15) || (a % 4 != 0) || (is_wr && a == 12'd8);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        if (m_err(a, 1'b0)) return 32'h0;
        case (a)
            12'd0:   return m_ctrl;
            12'd4:   return m_scratch;
            12'd8:   return status_in;
            default: return {24'h0, m_int};
        endcase
    endfunction

    function automatic bit m_irq();
        return |(m_int & m_ctrl[7:0]);
    endfunction

    task automatic m_reset();
        m_ctrl = 32'h0;
        m_scratch = SCR_RST;
        m_int = 8'h0;
    endtask

    task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [7:0] setv);
        if (!m_err(a, 1'b1)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b] && a == 12'd0) m_ctrl[8*b +: 8] = d[8*b +: 8];
                if (s[b] && a == 12'd4) m_scratch[8*b +: 8] = d[8*b +: 8];
            end
            if (a == 12'd12 && s[0]) m_int = m_int & ~d[7:0];
        end
        m_int = m_int | setv;
    endtask

    task automatic do_read(input logic [11:0] a, input bit hold,
                           output logic [31:0] d, output logic e, output int lat);
        @(posedge pclk); #1;
        bus.addr = a;
        bus.read_en = 1'b1;
        bus.write_en = 1'b0;
        lat = -1; d = 32'h0; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge pclk); #1;
            if (bus.rd_ready) begin
                lat = n; d = bus.rdata; e = bus.err_resp;
                break;
            end
        end
        if (!hold) bus.read_en = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [7:0] setv, output logic e, output int lat);
        @(posedge pclk); #1;
        bus.addr = a; bus.wdata = d; bus.w_strb = s;
        bus.read_en = 1'b0; bus.write_en = 1'b0;
        @(posedge pclk); #1;
        bus.write_en = 1'b1;
        lat = -1; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge pclk); #1;
            if (bus.wr_ready) begin
                lat = n; e = bus.err_resp;
                int_set = setv;
                break;
            end
        end
        bus.write_en = 1'b0;
        @(posedge pclk); #1;
        int_set = 8'h0;
    endtask

    task automatic pulse_int(input logic [7:0] v);
        @(posedge pclk); #1;
        int_set = v;
        @(posedge pclk); #1;
        int_set = 8'h0;
        m_int = m_int | v;
    endtask

    task automatic test_reset();
        prst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        m_reset();
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected %h", bus.rdata, 32'h0); end
        vectors++; if ({bus.rd_ready, bus.wr_ready, bus.err_resp} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {bus.rd_ready, bus.wr_ready, bus.err_resp}); end
        vectors++; if (ctrl_out !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 0", ctrl_out); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
        prst_n = 1'b1;
    endtask

    task automatic test_scratch_rst();
        logic [31:0] d; logic e; int lat;
        do_read(12'h004, 1'b0, d, e, lat);
        vectors++; if (d !== SCR_RST) begin miscompares++; $display("FAIL scratch_rst_data: got %h expected %h", d, SCR_RST); end
        vectors++; if (lat != 2 + RD_WAIT) begin miscompares++; $display("FAIL scratch_rst_latency: got %0d expected %0d", lat, 2 + RD_WAIT); end
        vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL scratch_rst_err: got %b expected 0", e); end
        @(posedge pclk); #1;
        vectors++; if (bus.rd_ready !== 1'b0) begin miscompares++; $display("FAIL rd_ready_pulse_width: got %b expected 0", bus.rd_ready); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; logic e; int lat;
        do_write(12'h000, 32'h1234_5678, 4'b0101, 8'h0, e, lat);
        m_write(12'h000, 32'h1234_5678, 4'b0101, 8'h0);
        vectors++; if (lat != 2 + WR_WAIT) begin miscompares++; $display("FAIL wr_latency: got %0d expected %0d", lat, 2 + WR_WAIT); end
        vectors++; if (ctrl_out !== 32'h0034_0078) begin miscompares++; $display("FAIL ctrl_out_lanes: got %h expected %h", ctrl_out, 32'h0034_0078); end
        do_read(12'h000, 1'b0, d, e, lat);
        vectors++; if (d !== m_read(12'h000)) begin miscompares++; $display("FAIL ctrl_readback: got %h expected %h", d, m_read(12'h000)); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat;
        status_in = 32'h5EED_0042;
        do_write(12'h008, 32'hFFFF_FFFF, 4'hF, 8'h0, e, lat);
        m_write(12'h008, 32'hFFFF_FFFF, 4'hF, 8'h0);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL status_write_err: got %b expected 1", e); end
        do_read(12'h008, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h5EED_0042) begin miscompares++; $display("FAIL status_read: got %h expected %h", d, 32'h5EED_0042); end
        do_read(12'h010, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h0 || e !== 1'b1) begin miscompares++; $display("FAIL unmapped_read: got %h/%b expected 0/1", d, e); end
        do_read(12'h002, 1'b0, d, e, lat);
        vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL misaligned_read: got %b expected 1", e); end
        vectors++; if (ctrl_out !== m_ctrl) begin miscompares++; $display("FAIL err_no_side_effect: got %h expected %h", ctrl_out, m_ctrl); end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic e; int lat;
        do_write(12'h000, 32'h0000_0001, 4'hF, 8'h0, e, lat);
        m_write(12'h000, 32'h0000_0001, 4'hF, 8'h0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b expected 0", irq); end
        pulse_int(8'h03);
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b expected 1", irq); end
        do_write(12'h00C, 32'h0000_0001, 4'b0001, 8'h01, e, lat);
        m_write(12'h00C, 32'h0000_0001, 4'b0001, 8'h01);
        do_read(12'h00C, 1'b0, d, e, lat);
        vectors++; if (d !== 32'h0000_0003) begin miscompares++; $display("FAIL set_beats_clear: got %h expected %h", d, 32'h3); end
        do_write(12'h00C, 32'h0000_00FF, 4'b0000, 8'h0, e, lat);
        m_write(12'h00C, 32'h0000_00FF, 4'b0000, 8'h0);
        do_read(12'h00C, 1'b0, d, e, lat);
        vectors++; if (d !== m_read(12'h00C) || e !== 1'b0) begin miscompares++; $display("FAIL zero_strb_noop: got %h/%b expected %h/0", d, e, m_read(12'h00C)); end
        do_write(12'h00C, 32'hFFFF_FF03, 4'b0001, 8'h0, e, lat);
        m_write(12'h00C, 32'hFFFF_FF03, 4'b0001, 8'h0);
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b expected 0", irq); end
        pulse_int(8'h02);
        vectors++; if (irq !== m_irq()) begin miscompares++; $display("FAIL irq_masked: got %b expected %b", irq, m_irq()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d0, d1; logic e0, e1; int l0, l1;
        do_write(12'h004, 32'hBEEF_CAFE, 4'hF, 8'h0, e0, l0);
        m_write(12'h004, 32'hBEEF_CAFE, 4'hF, 8'h0);
        do_read(12'h000, 1'b1, d0, e0, l0);
        do_read(12'h004, 1'b0, d1, e1, l1);
        vectors++; if (d0 !== m_read(12'h000)) begin miscompares++; $display("FAIL b2b_first: got %h expected %h", d0, m_read(12'h000)); end
        vectors++; if (d1 !== m_read(12'h004)) begin miscompares++; $display("FAIL b2b_second: got %h expected %h", d1, m_read(12'h004)); end
        vectors++; if (l1 != 2 + RD_WAIT) begin miscompares++; $display("FAIL b2b_latency: got %0d expected %0d", l1, 2 + RD_WAIT); end
    endtask

    task automatic test_random();
        logic [31:0] d, rd; logic e; int lat; logic [11:0] a; logic [3:0] s; logic [7:0] sv;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: a = 12'h000;
                1: a = 12'h004;
                2: a = 12'h008;
                3: a = 12'h00C;
                default: a = 12'($urandom_range(0, 4095));
            endcase
            status_in = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                sv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
                do_write(a, d, s, sv, e, lat);
                m_write(a, d, s, sv);
                vectors++; if (e !== m_err(a, 1'b1)) begin miscompares++; $display("FAIL rnd_wr_err[%0d]: addr %h got %b expected %b", i, a, e, m_err(a, 1'b1)); end
                vectors++; if (lat != 2 + WR_WAIT) begin miscompares++; $display("FAIL rnd_wr_lat[%0d]: got %0d expected %0d", i, lat, 2 + WR_WAIT); end
                vectors++; if (ctrl_out !== m_ctrl) begin miscompares++; $display("FAIL rnd_ctrl[%0d]: got %h expected %h", i, ctrl_out, m_ctrl); end
            end else begin
                do_read(a, 1'b0, rd, e, lat);
                vectors++; if (rd !== m_read(a)) begin miscompares++; $display("FAIL rnd_rd_data[%0d]: addr %h got %h expected %h", i, a, rd, m_read(a)); end
                vectors++; if (e !== m_err(a, 1'b0)) begin miscompares++; $display("FAIL rnd_rd_err[%0d]: addr %h got %b expected %b", i, a, e, m_err(a, 1'b0)); end
                vectors++; if (lat != 2 + RD_WAIT) begin miscompares++; $display("FAIL rnd_rd_lat[%0d]: got %0d expected %0d", i, lat, 2 + RD_WAIT); end
            end
            if ($urandom_range(0, 3) == 0) pulse_int(8'($urandom));
            vectors++; if (irq !== m_irq()) begin miscompares++; $display("FAIL rnd_irq[%0d]: got %b expected %b", i, irq, m_irq()); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat;
        do_write(12'h004, 32'h1111_2222, 4'hF, 8'h0, e, lat);
        do_write(12'h000, 32'h0000_00FF, 4'hF, 8'h0, e, lat);
        pulse_int(8'h81);
        @(posedge pclk); #1;
        bus.addr = 12'h004;
        bus.read_en = 1'b1;
        @(posedge pclk); #1;
        prst_n = 1'b0;
        bus.read_en = 1'b0;
        m_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            vectors++; if ({bus.rd_ready, bus.err_resp, irq} !== 3'b000 || bus.rdata !== 32'h0 || ctrl_out !== 32'h0) begin
                miscompares++; $display("FAIL mid_reset_outputs[%0d]: got rdy/err/irq %b rdata %h ctrl %h expected all 0", c, {bus.rd_ready, bus.err_resp, irq}, bus.rdata, ctrl_out);
            end
            @(posedge pclk); #1;
        end
        prst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge pclk); #1;
            vectors++; if (bus.rd_ready !== 1'b0) begin miscompares++; $display("FAIL aborted_read_pulse[%0d]: got %b expected 0", c, bus.rd_ready); end
        end
        do_read(12'h004, 1'b0, d, e, lat);
        vectors++; if (d !== SCR_RST) begin miscompares++; $display("FAIL scratch_after_reset: got %h expected %h", d, SCR_RST); end
    endtask

    initial begin
        bus.addr = 12'h0;
        bus.wdata = 32'h0;
        bus.w_strb = 4'h0;
        bus.write_en = 1'b0;
        bus.read_en = 1'b0;
        status_in = 32'hCAFE_0001;
        int_set = 8'h0;
        prst_n = 1'b0;
        test_reset();
        test_scratch_rst();
        test_byte_lanes();
        test_errors();
        test_irq();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
